// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider FSM state encoding and ALU opcode constants.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2
    } div_state_e;

    typedef enum logic [2:0] {
        ADD = 3'b000,
        SUB = 3'b001,
        MUL = 3'b010,
        DIV = 3'b011
    } alu_op_e;

    localparam int DIV_WIDTH_DEFAULT = 16;

endpackage

// File: rtl/div_step.sv
// One restoring division step: shift in the next dividend bit, trial-subtract
// the divisor, and keep the difference only when it did not go negative.
module div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             dvd_msb_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // The partial remainder stays below the divisor magnitude (at most
    // 2^(WIDTH-1)), so one extra bit is enough to carry the borrow.
    always_comb begin
        shifted = {rem_i, dvd_msb_i};
        diff    = shifted - {1'b0, divisor_i};
        q_bit_o = ~diff[WIDTH];
        rem_o   = q_bit_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/restoring_div_16.sv
// Sequential signed restoring divider (IDLE -> CALC x WIDTH -> SIGN).
// Define DIV_ZERO_FLAG_EN to add the div_zero output flag.
module restoring_div_16
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done,
    output logic             busy,
    output div_state_e       dbg_state_o
`ifdef DIV_ZERO_FLAG_EN
    ,
    output logic             div_zero
`endif
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    // start/done handshake: start is a one-cycle request that is only looked
    // at while IDLE; done is a one-cycle pulse that coincides with the new
    // quotient/remainder, which then hold until the next SIGN state.

    div_state_e       state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             a_neg_q, a_neg_d;
    logic             q_neg_q, q_neg_d;
    logic             bzero_q, bzero_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rmd_q, rmd_d;
    logic             done_q, done_d;
`ifdef DIV_ZERO_FLAG_EN
    logic             dz_q, dz_d;
`endif

    logic [WIDTH-1:0] step_rem;
    logic             step_q;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .divisor_i (dsr_q),
        .dvd_msb_i (dvd_q[WIDTH-1]),
        .rem_o     (step_rem),
        .q_bit_o   (step_q)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        rem_d   = rem_q;
        a_neg_d = a_neg_q;
        q_neg_d = q_neg_q;
        bzero_d = bzero_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        done_d  = 1'b0;
`ifdef DIV_ZERO_FLAG_EN
        dz_d    = dz_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d   = A[WIDTH-1] ? -A : A;
                    dsr_d   = B[WIDTH-1] ? -B : B;
                    a_neg_d = A[WIDTH-1];
                    q_neg_d = A[WIDTH-1] ^ B[WIDTH-1];
                    bzero_d = (B == '0);
                    rem_d   = '0;
                    count_d = CW'(WIDTH - 1);
                    state_d = CALC;
                end
            end
            CALC: begin
                // Dividend register shifts out its MSB and collects quotient bits.
                rem_d = step_rem;
                dvd_d = {dvd_q[WIDTH-2:0], step_q};
                if (count_q == '0) begin
                    state_d = SIGN;
                end else begin
                    count_d = count_q - CW'(1);
                end
            end
            SIGN: begin
                // With a zero divisor the remainder already equals |A|, so only
                // the quotient needs forcing to -1.
                quo_d   = bzero_q ? '1 : (q_neg_q ? -dvd_q : dvd_q);
                rmd_d   = a_neg_q ? -rem_q : rem_q;
                done_d  = 1'b1;
`ifdef DIV_ZERO_FLAG_EN
                dz_d    = bzero_q;
`endif
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            rem_q   <= '0;
            a_neg_q <= 1'b0;
            q_neg_q <= 1'b0;
            bzero_q <= 1'b0;
            quo_q   <= '0;
            rmd_q   <= '0;
            done_q  <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
            dz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            rem_q   <= rem_d;
            a_neg_q <= a_neg_d;
            q_neg_q <= q_neg_d;
            bzero_q <= bzero_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            done_q  <= done_d;
`ifdef DIV_ZERO_FLAG_EN
            dz_q    <= dz_d;
`endif
        end
    end

    assign quotient    = quo_q;
    assign remainder   = rmd_q;
    assign done        = done_q;
    assign busy        = (state_q != IDLE);
    assign dbg_state_o = state_q;
`ifdef DIV_ZERO_FLAG_EN
    assign div_zero    = dz_q;
`endif

endmodule
